// File: rtl/bind_xor_mon.sv
// rtl/bind_xor_mon.sv - XOR-cell checker with first-failure report, error counter and sticky flag
//
// Watches LANES instances of a bound XOR cell (c = a ^ b). While armed, the first
// mismatching cycle is captured into a report (lowest failing lane and the cycle
// stamp). The report is held until it is accepted with a valid/ready handshake.
// Every mismatch cycle bumps a saturating counter and sets a sticky flag.
//
// Optional feature: define BIND_XOR_MON_ASSERT_EN to add one immediate assertion
// per lane that checks c[i] == a[i] ^ b[i] while en=1 and rst=0.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset (highest priority)
//   en                - arms monitoring; a lane can only mismatch while en=1
//   clr               - clears err_cnt and err_sticky (FSM, report and stamp untouched)
//   a, b, c           - per-lane operands and observed XOR result
//   rpt_valid/ready   - first-failure report handshake
//   rpt_lane          - lowest mismatching lane of the reported failure
//   rpt_stamp         - stamp of the cycle in which the failure was captured
//   err_cnt           - saturating count of mismatch cycles
//   err_sticky        - a mismatch occurred since the last reset or clear
module bind_xor_mon #(
    parameter int LANES   = 2,
    parameter int CNT_W   = 8,
    parameter int STAMP_W = 16,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [LANES-1:0]   a,
    input  logic [LANES-1:0]   b,
    input  logic [LANES-1:0]   c,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [LANE_W-1:0]  rpt_lane,
    output logic [STAMP_W-1:0] rpt_stamp,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               err_sticky
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [STAMP_W-1:0] rstamp_q, rstamp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;

    logic [LANES-1:0]   mis_vec;
    logic               mis_any;
    logic [LANE_W-1:0]  first_lane;
    logic               hs;

    assign mis_vec = {LANES{en}} & (c ^ (a ^ b));
    assign mis_any = |mis_vec;

    // Scan from the top down so the lowest failing lane wins.
    always_comb begin
        first_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mis_vec[i]) begin
                first_lane = LANE_W'(i);
            end
        end
    end

    assign hs = (state_q == HOLD) && rpt_ready;

    always_comb begin
        state_d  = state_q;
        stamp_d  = stamp_q;
        lane_d   = lane_q;
        rstamp_d = rstamp_q;
        unique case (state_q)
            IDLE: begin
                stamp_d = '0;
                if (en) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!en) begin
                    state_d = IDLE;
                    stamp_d = '0;
                end else begin
                    stamp_d = stamp_q + STAMP_W'(1);
                    if (mis_any) begin
                        state_d  = HOLD;
                        lane_d   = first_lane;
                        rstamp_d = stamp_q;
                    end
                end
            end
            HOLD: begin
                stamp_d = stamp_q + STAMP_W'(1);
                // Mismatches while holding are ignored unless the report is
                // being consumed in the same cycle; then the new one replaces it.
                if (hs) begin
                    if (mis_any) begin
                        lane_d   = first_lane;
                        rstamp_d = stamp_q;
                    end else if (en) begin
                        state_d = ARMED;
                    end else begin
                        state_d = IDLE;
                        stamp_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                stamp_d = '0;
            end
        endcase
    end

    // A clear in a mismatch cycle still records that mismatch.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q | mis_any;
        if (clr) begin
            cnt_d    = mis_any ? CNT_W'(1) : '0;
            sticky_d = mis_any;
        end else if (mis_any && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            stamp_q  <= '0;
            lane_q   <= '0;
            rstamp_q <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            stamp_q  <= stamp_d;
            lane_q   <= lane_d;
            rstamp_q <= rstamp_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign rpt_valid  = (state_q == HOLD);
    assign rpt_lane   = lane_q;
    assign rpt_stamp  = rstamp_q;
    assign err_cnt    = cnt_q;
    assign err_sticky = sticky_q;

`ifdef BIND_XOR_MON_ASSERT_EN
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (en && !rst) begin
                assert (c[i] == (a[i] ^ b[i]));
            end
        end
    end
`else
    // Checker assertions are compiled out; port behaviour is unchanged.
`endif

endmodule

// File: doc/bind_xor_mon.md
BIND_XOR_MON -- requirements
Module: bind_xor_mon

Interface
REQ-001 The module SHALL have parameter LANES, default 2, giving the number of monitored XOR lanes (1..16).
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the width of the error counter.
REQ-003 The module SHALL have parameter STAMP_W, default 16, giving the width of the cycle stamp.
REQ-004 Derived width LANE_W SHALL be max(1, clog2(LANES)).
REQ-005 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port en, input, 1: arms monitoring when high.
REQ-008 Port clr, input, 1: clears err_cnt and err_sticky.
REQ-009 Ports a, b, c, input, LANES each: per-lane operands and the observed result of the bound XOR cell.
REQ-010 Port rpt_valid, output, 1: a first-failure report is pending.
REQ-011 Port rpt_ready, input, 1: the consumer accepts the report.
REQ-012 Port rpt_lane, output, LANE_W: lowest mismatching lane of the reported failure.
REQ-013 Port rpt_stamp, output, STAMP_W: stamp value of the reported failure.
REQ-014 Port err_cnt, output, CNT_W: count of mismatch cycles, saturating.
REQ-015 Port err_sticky, output, 1: a mismatch has occurred since the last reset or clear.

Function
REQ-016 Lane i SHALL mismatch when en=1 and c[i] != a[i]^b[i]; mis_any is the OR over all lanes.
REQ-017 The FSM SHALL have three states: IDLE, ARMED and HOLD.
REQ-018 The FSM SHALL go IDLE->ARMED on en=1 and ARMED->IDLE on en=0.
REQ-019 The FSM SHALL go ARMED->HOLD on mis_any=1.
REQ-020 The FSM SHALL leave HOLD only on the handshake rpt_valid&rpt_ready: to ARMED if en=1, otherwise to IDLE.
REQ-021 In HOLD, en=0 SHALL NOT drop the report; rpt_valid stays high until the handshake.
REQ-022 rpt_valid SHALL be 1 exactly when the state is HOLD.
REQ-023 rpt_lane and rpt_stamp SHALL be stable while rpt_valid=1.
REQ-024 The report SHALL be registered: a mismatch sampled at edge N gives rpt_valid=1 after edge N, i.e. 1-cycle latency.
REQ-025 rpt_lane SHALL be the lowest-index mismatching lane in the capture cycle.
REQ-026 rpt_stamp SHALL be the stamp value in the capture cycle.
REQ-027 Mismatches occurring while in HOLD SHALL NOT overwrite the pending report.
REQ-028 A handshake and a new mismatch in the same cycle SHALL complete the handshake and capture the new mismatch, staying in HOLD with new values, when en=1.
REQ-029 The stamp SHALL be zero in IDLE and increment by 1 each cycle in ARMED or HOLD, wrapping from all-ones to 0.
REQ-030 The stamp SHALL load 0 on the IDLE->ARMED transition.
REQ-031 err_cnt SHALL increment by 1 per cycle with mis_any=1, in any state with en=1, and saturate at 2^CNT_W-1.
REQ-032 err_sticky SHALL be set by mis_any=1 and cleared only by rst or clr.
REQ-033 With clr=1 alone, err_cnt SHALL load 0 and err_sticky SHALL load 0.
REQ-034 With clr=1 and mis_any=1 in the same cycle, err_cnt SHALL load 1 and err_sticky SHALL load 1.
REQ-035 clr SHALL NOT affect the FSM, the pending report or the stamp.

Reset
REQ-036 rst SHALL take priority over every other input.
REQ-037 After a reset edge: state=IDLE, rpt_valid=0, rpt_lane=0, rpt_stamp=0, stamp=0, err_cnt=0, err_sticky=0.
REQ-038 Reset asserted while in HOLD SHALL discard the pending report with no handshake.

Configuration
REQ-039 With BIND_XOR_MON_ASSERT_EN defined, the module SHALL contain one immediate assertion per lane in a combinational block, asserting c[i]==a[i]^b[i] whenever en=1 and rst=0.
REQ-040 Without BIND_XOR_MON_ASSERT_EN, no assertions SHALL be present and all port behaviour SHALL be identical.

Verification
REQ-041 Scenario: rst 1 cycle, then en=1, all lanes correct for 20 cycles -> rpt_valid=0, err_cnt=0, err_sticky=0.
REQ-042 Scenario: en=1 at stamp 0, then lane 1 with a=1, b=0, c=0 at stamp 5, rpt_ready=0 -> next cycle rpt_valid=1, rpt_lane=1, rpt_stamp=5, err_cnt=1; values held for 10 cycles.
REQ-043 Scenario: lanes 0 and 1 mismatch in the same cycle -> rpt_lane=0.
REQ-044 Scenario: a second mismatch while in HOLD -> report unchanged and err_cnt=2.
REQ-045 Scenario: handshake together with a new mismatch at stamp 9 -> rpt_valid stays 1 and rpt_stamp=9.
REQ-046 Scenario: CNT_W=2, 5 consecutive mismatch cycles -> err_cnt=3.
REQ-047 Scenario: clr with a simultaneous mismatch -> err_cnt=1.
REQ-048 Scenario: rst asserted during HOLD -> rpt_valid=0 on the next cycle.
